// File: rtl/mul_iter_seq.sv
// Iterated-multiply sequencer: Rd = Rm * Rs^N (mod 2^DATA_W) on a register file,
// using an external multiplier and one read pair / one write port.
module mul_iter_seq #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 6,
    parameter int RD_LAT  = 1,
    parameter int MUL_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rm,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] mul_rs,
    output logic [DATA_W-1:0] mul_rm,
    input  logic [DATA_W-1:0] mul_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, RD, RDW, MUL, WB, DONE} state_t;

    localparam logic [7:0] RD_LAST  = 8'(RD_LAT - 1);
    localparam logic [7:0] MUL_LAST = 8'(MUL_LAT);

    state_t            state_q, state_d;
    logic [7:0]        wait_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] rs_addr_q, rm_addr_q, rd_addr_q;
    logic [DATA_W-1:0] rs_q, rm_q, res_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_d = (cmd_count == '0) ? DONE : RD;
            end
            RD: begin
                rd_en   = 1'b1;
                state_d = RDW;
            end
            RDW: if (wait_q == RD_LAST) state_d = MUL;
            MUL: if (wait_q == MUL_LAST) state_d = WB;
            WB: begin
                wr_en   = !abort;
                state_d = (cnt_q > CNT_W'(1)) ? MUL : DONE;
            end
            DONE: begin
                done    = !abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // abort overrides any transition once a command is running
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q    <= '0;
            cnt_q     <= '0;
            rs_addr_q <= '0;
            rm_addr_q <= '0;
            rd_addr_q <= '0;
            rs_q      <= '0;
            rm_q      <= '0;
            res_q     <= '0;
        end else begin
            if (state_d != state_q)                 wait_q <= '0;
            else if (state_q == RDW || state_q == MUL) wait_q <= wait_q + 8'd1;

            if (state_q == IDLE && cmd_valid) begin
                rs_addr_q <= cmd_rs;
                rm_addr_q <= cmd_rm;
                rd_addr_q <= cmd_rd;
                cnt_q     <= cmd_count;
            end
            if (state_q == RDW && state_d == MUL) begin
                rs_q <= rd_data_a;
                rm_q <= rd_data_b;
            end
            if (state_q == MUL && state_d == WB) res_q <= mul_result;
            // product feeds back as the next Rm; Rs stays from the single read
            if (state_q == WB && state_d == MUL) begin
                cnt_q <= cnt_q - CNT_W'(1);
                rm_q  <= res_q;
            end
        end
    end

    assign rd_addr_a = rs_addr_q;
    assign rd_addr_b = rm_addr_q;
    assign mul_rs    = rs_q;
    assign mul_rm    = rm_q;
    assign wr_addr   = rd_addr_q;
    assign wr_data   = res_q;

endmodule

// File: tb/tb_mul_iter_seq.sv
// Bench for mul_iter_seq: two instances (default latencies and RD_LAT=2/MUL_LAT=1) with
// register-file and multiplier models and a write scoreboard.
module tb_mul_iter_seq;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk, rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt0 = 0;
    wr_t  q0[$];
    wr_t  q1[$];

    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] rf0 [16];
    logic [31:0] rf1 [16];
    logic [31:0] p1a, p1b, mul_pipe1;

    logic        cmd_valid0, cmd_ready0, abort0, rd_en0, wr_en0, busy0, done0;
    logic [3:0]  cmd_rs0, cmd_rm0, cmd_rd0, rd_addr_a0, rd_addr_b0, wr_addr0;
    logic [5:0]  cmd_count0;
    logic [31:0] rd_data_a0, rd_data_b0, mul_rs0, mul_rm0, mul_result0, wr_data0;

    logic        cmd_valid1, cmd_ready1, rd_en1, wr_en1, busy1, done1;
    logic [3:0]  cmd_rs1, cmd_rm1, cmd_rd1, rd_addr_a1, rd_addr_b1, wr_addr1;
    logic [5:0]  cmd_count1;
    logic [31:0] rd_data_a1, rd_data_b1, mul_rs1, mul_rm1, mul_result1, wr_data1;

    mul_iter_seq dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_rs(cmd_rs0), .cmd_rm(cmd_rm0), .cmd_rd(cmd_rd0), .cmd_count(cmd_count0),
        .abort(abort0), .rd_en(rd_en0), .rd_addr_a(rd_addr_a0), .rd_addr_b(rd_addr_b0),
        .rd_data_a(rd_data_a0), .rd_data_b(rd_data_b0), .mul_rs(mul_rs0), .mul_rm(mul_rm0),
        .mul_result(mul_result0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .busy(busy0), .done(done0)
    );

    mul_iter_seq #(.RD_LAT(2), .MUL_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_rs(cmd_rs1), .cmd_rm(cmd_rm1), .cmd_rd(cmd_rd1), .cmd_count(cmd_count1),
        .abort(1'b0), .rd_en(rd_en1), .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1),
        .rd_data_a(rd_data_a1), .rd_data_b(rd_data_b1), .mul_rs(mul_rs1), .mul_rm(mul_rm1),
        .mul_result(mul_result1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file models: dut0 sees data one cycle after rd_en, dut1 two cycles after.
    always @(posedge clk) begin
        if (ld_en) begin
            rf0[ld_addr] <= ld_data;
            rf1[ld_addr] <= ld_data;
        end else begin
            if (wr_en0) rf0[wr_addr0] <= wr_data0;
            if (wr_en1) rf1[wr_addr1] <= wr_data1;
        end
        if (rd_en0) begin
            rd_data_a0 <= rf0[rd_addr_a0];
            rd_data_b0 <= rf0[rd_addr_b0];
        end
        if (rd_en1) begin
            p1a <= rf1[rd_addr_a1];
            p1b <= rf1[rd_addr_b1];
        end
        rd_data_a1 <= p1a;
        rd_data_b1 <= p1b;
        mul_pipe1  <= mul_rs1 * mul_rm1;
    end

    assign mul_result0 = mul_rs0 * mul_rm0;
    assign mul_result1 = mul_pipe1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Write monitors: every wr_en must match the head of its scoreboard queue.
    always @(negedge clk) begin
        wr_t e;
        #2;
        if (wr_en0 === 1'b1) begin
            if (q0.size() == 0) check("wr0_unexpected", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("wr0_addr", 32'(wr_addr0), 32'(e.addr));
                check("wr0_data", wr_data0, e.data);
                check("wr0_cycle", cyc, e.cyc);
            end
        end
        if (wr_en1 === 1'b1) begin
            if (q1.size() == 0) check("wr1_unexpected", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("wr1_addr", 32'(wr_addr1), 32'(e.addr));
                check("wr1_data", wr_data1, e.data);
                check("wr1_cycle", cyc, e.cyc);
            end
        end
        if (done0 === 1'b1) done_cnt0++;
    end

    function automatic logic [31:0] pow_prod(input logic [31:0] rm_v, input logic [31:0] rs_v,
                                             input int k);
        logic [31:0] v;
        v = rm_v;
        for (int i = 0; i < k; i++) v = v * rs_v;
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Expected dut0 writes for iterations 1..n of a command accepted at cycle t.
    task automatic expect_writes0(input logic [3:0] rd, input logic [31:0] rm_v,
                                  input logic [31:0] rs_v, input int n, input int t);
        wr_t e;
        for (int k = 1; k <= n; k++) begin
            e.addr = rd;
            e.data = pow_prod(rm_v, rs_v, k);
            e.cyc  = t + 2 + 2 * k;
            q0.push_back(e);
        end
    endtask

    task automatic issue0(input logic [3:0] rs, input logic [3:0] rm, input logic [3:0] rd,
                          input logic [5:0] n, output int t);
        cmd_rs0 = rs; cmd_rm0 = rm; cmd_rd0 = rd; cmd_count0 = n;
        cmd_valid0 = 1'b1;
        t = cyc;
        check("ready_at_issue", 32'(cmd_ready0), 32'd1);
        tick();
        cmd_valid0 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int exp_c, input string tag);
        int seen;
        seen = -1;
        for (int i = 0; i < 300; i++) begin
            if ((sel ? done1 : done0) === 1'b1) begin
                seen = cyc;
                break;
            end
            tick();
        end
        check(tag, seen, exp_c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t, t2, dc;
        wr_t e;
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        cmd_valid0 = 1'b0; cmd_rs0 = '0; cmd_rm0 = '0; cmd_rd0 = '0; cmd_count0 = '0; abort0 = 1'b0;
        cmd_valid1 = 1'b0; cmd_rs1 = '0; cmd_rm1 = '0; cmd_rd1 = '0; cmd_count1 = '0;
        repeat (3) tick();

        check("rst_ready0", 32'(cmd_ready0), 32'd1);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_wr_data0", wr_data0, 32'd0);
        check("rst_ready1", 32'(cmd_ready1), 32'd1);
        rst_n = 1'b1;

        load(4'd0, 32'd2);
        load(4'd1, 32'd1);
        load(4'd2, 32'h55);
        load(4'd3, 32'd3);
        load(4'd4, 32'd5);

        // Slow-latency instance, single iteration: write at T+6, done at T+7
        cmd_rs1 = 4'd0; cmd_rm1 = 4'd1; cmd_rd1 = 4'd2; cmd_count1 = 6'd1;
        cmd_valid1 = 1'b1;
        t = cyc;
        e.addr = 4'd2; e.data = 32'd2; e.cyc = t + 6;
        q1.push_back(e);
        tick();
        cmd_valid1 = 1'b0;
        check("lat_rd_en", 32'(rd_en1), 32'd1);
        wait_done(1'b1, t + 7, "lat_done_cycle");
        tick();
        check("lat_ready", 32'(cmd_ready1), 32'd1);

        // N=1
        issue0(4'd0, 4'd1, 4'd2, 6'd1, t);
        expect_writes0(4'd2, 32'd1, 32'd2, 1, t);
        check("n1_rd_en", 32'(rd_en0), 32'd1);
        check("n1_rd_addr_b", 32'(rd_addr_b0), 32'd1);
        wait_done(1'b0, t + 5, "n1_done_cycle");
        tick();
        check("n1_ready", 32'(cmd_ready0), 32'd1);
        check("n1_sb_empty", q0.size(), 32'd0);

        // N=30: powers of two up to 2^30
        issue0(4'd0, 4'd1, 4'd2, 6'd30, t);
        expect_writes0(4'd2, 32'd1, 32'd2, 30, t);
        wait_done(1'b0, t + 63, "n30_done_cycle");
        check("n30_sb_empty", q0.size(), 32'd0);
        check("n30_final_r2", rf0[2], 32'h4000_0000);
        tick();

        // N=33: wraps to 0 from the 32nd iteration
        issue0(4'd0, 4'd1, 4'd2, 6'd33, t);
        expect_writes0(4'd2, 32'd1, 32'd2, 33, t);
        wait_done(1'b0, t + 69, "n33_done_cycle");
        check("n33_sb_empty", q0.size(), 32'd0);
        check("n33_final_r2", rf0[2], 32'd0);
        tick();

        // N=0: straight to DONE, no read or write
        issue0(4'd0, 4'd1, 4'd2, 6'd0, t);
        check("n0_rd_en", 32'(rd_en0), 32'd0);
        check("n0_done", 32'(done0), 32'd1);
        check("n0_ready_busy", 32'(cmd_ready0), 32'd0);
        tick();
        check("n0_ready_after", 32'(cmd_ready0), 32'd1);

        // Reset in the first MUL cycle of an N=3 run: no write, no done afterwards
        dc = done_cnt0;
        issue0(4'd0, 4'd1, 4'd2, 6'd3, t);
        tick();
        tick();
        check("rst_mid_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rstm_ready", 32'(cmd_ready0), 32'd1);
        check("rstm_outs", {26'd0, rd_en0, wr_en0, busy0, done0, 2'b00}, 32'd0);
        check("rstm_addrs", {20'd0, rd_addr_a0, rd_addr_b0, wr_addr0}, 32'd0);
        check("rstm_mul_rs", mul_rs0, 32'd0);
        check("rstm_mul_rm", mul_rm0, 32'd0);
        check("rstm_wr_data", wr_data0, 32'd0);
        rst_n = 1'b1;
        repeat (8) tick();
        check("rstm_no_done", done_cnt0, dc);

        // cmd_valid held: A (rd==rm) completes before B is accepted; abort in B's 3rd WB
        cmd_rs0 = 4'd0; cmd_rm0 = 4'd1; cmd_rd0 = 4'd1; cmd_count0 = 6'd2;
        cmd_valid0 = 1'b1;
        t = cyc;
        expect_writes0(4'd1, 32'd1, 32'd2, 2, t);
        tick();
        cmd_rs0 = 4'd3; cmd_rm0 = 4'd4; cmd_rd0 = 4'd5; cmd_count0 = 6'd5;
        check("hold_ready_low", 32'(cmd_ready0), 32'd0);
        t2 = t + 8;
        expect_writes0(4'd5, 32'd5, 32'd3, 2, t2);
        wait_done(1'b0, t + 7, "hold_a_done_cycle");
        tick();
        check("hold_b_accept", 32'(cmd_ready0), 32'd1);
        tick();
        cmd_valid0 = 1'b0;
        check("hold_b_rd_en", 32'(rd_en0), 32'd1);
        check("hold_b_rs_addr", 32'(rd_addr_a0), 32'd3);
        while (cyc < t2 + 8) tick();
        dc = done_cnt0;
        abort0 = 1'b1;
        #1;
        check("abort_wr_en", 32'(wr_en0), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        tick();
        abort0 = 1'b0;
        check("abort_ready_next", 32'(cmd_ready0), 32'd1);
        check("abort_busy_next", 32'(busy0), 32'd0);
        repeat (6) tick();
        check("abort_no_done", done_cnt0, dc);
        check("abort_r1", rf0[1], 32'd4);
        check("abort_r5", rf0[5], 32'd45);
        check("final_sb0_empty", q0.size(), 32'd0);
        check("final_sb1_empty", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
